div_selector: RTL and testbench
===============================

// Module: div_selector
// PURPOSE
//  Produces the 7-bit divide value for the variable clock divider (div input) from two raw
//  push-buttons. Steps div up/down with debounce, hold-to-auto-repeat and saturating limits.
//  Timebase is the divider's 1 kHz square output (clk_1kHz), sampled as data in the clk domain.
//  Sits directly upstream of the divider; div changes at most once per ms.
// PARAMETERS
//  DIV_MIN          1    lowest div value; down-steps saturate here
//  DIV_MAX          99   highest div value; up-steps saturate here (<=127)
//  DIV_RESET        49   div value after reset (DIV_MIN<=DIV_RESET<=DIV_MAX)
//  DEB_MS           20   stable time, in ms ticks, before a button level is accepted (1..1023)
//  REPEAT_DELAY_MS  500  hold time from first step to first auto-repeat step (1..1023)
//  REPEAT_RATE_MS   100  interval between auto-repeat steps (1..1023)
// PORTS
//  clk       in   1  system clock (100 MHz); single clock domain
//  rst       in   1  synchronous, active-high reset
//  tick_src  in   1  1 kHz square wave from the divider (clk_1kHz); level, not a clock
//  btn_up    in   1  raw, asynchronous, bouncing push-button, active-high
//  btn_dn    in   1  raw, asynchronous, bouncing push-button, active-high
//  div       out  7  registered divide value to the divider
//  changed   out  1  one-clk pulse in the cycle div takes a new value
//  at_min    out  1  div == DIV_MIN (registered, same cycle as div)
//  at_max    out  1  div == DIV_MAX (registered, same cycle as div)
// BEHAVIOUR
//  - Reset: div=DIV_RESET, changed=0, at_min/at_max from DIV_RESET; all syncs, counters,
//    debounced levels (0) and FSM (IDLE) cleared. Reset mid-press/mid-repeat aborts fully;
//    a held button after reset is debounced again and counts as a new press.
//  - tick_src, btn_up, btn_dn each pass a 2-FF synchronizer. ms_tick = rising edge of the
//    synchronized tick_src (1-clk pulse, 1 per ms). All timers advance only on ms_tick.
//  - Debounce per button: 10-bit counter cleared whenever sync level == debounced level;
//    else increments on ms_tick; at DEB_MS debounced level takes sync level, counter clears.
//    Glitches shorter than DEB_MS ticks never change the debounced level.
//  - FSM on debounced up (U), dn (D); 10-bit ms timer T:
//    IDLE:   U&!D rising -> issue +1, T=0, HOLD. D&!U rising -> issue -1, T=0, HOLD.
//            U&D -> LOCK.
//    HOLD:   button released -> IDLE; other button also pressed -> LOCK;
//            T reaches REPEAT_DELAY_MS -> issue step, T=0, REPEAT.
//    REPEAT: released -> IDLE; other pressed -> LOCK; T reaches REPEAT_RATE_MS -> step, T=0.
//    LOCK:   no steps; -> IDLE only when U=0 and D=0.
//  - Both debounced levels rising in the same cycle -> LOCK, no step.
//  - Step: div+1 / div-1 in 7-bit unsigned, clamped to [DIV_MIN,DIV_MAX]; no wrap.
//    Step at the limit leaves div unchanged and does NOT pulse changed.
//  - Latency: div, changed, at_min, at_max update in the clk cycle after the step decision.
//  - div is stable between steps (glitch-free register output); changed never asserts
//    on two consecutive cycles.
// TESTING
//  1 rst 5 clks -> div=49, changed=0, at_min=0, at_max=0; no change over 50 ms idle.
//  2 btn_up 8 ms pulses x5 (8 ms gaps) -> div stays 49, changed never asserts.
//  3 clean btn_up press -> div=50 exactly 20 ms ticks (+ <=4 clks) later, one changed pulse.
//  4 btn_up held; raw release 1150 ms after first step -> div 49->57 (steps at 0,500..1100 ms).
//  5 div at 98, hold btn_up 2 s -> div=99, at_max=1, exactly 1 changed pulse; same at DIV_MIN.
//  6 up+dn pressed together -> no step (LOCK) until both released; rst during REPEAT -> div=49.

Source files
------------

// File: rtl/div_selector.sv
// Push-button divide-value selector: synchronizes and debounces two buttons on a 1 ms timebase,
// then steps a saturating 7-bit divide value with hold-to-auto-repeat.
module div_selector #(
    parameter int DIV_MIN         = 1,
    parameter int DIV_MAX         = 99,
    parameter int DIV_RESET       = 49,
    parameter int DEB_MS          = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_src,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [6:0] div,
    output logic       changed,
    output logic       at_min,
    output logic       at_max
);

    localparam logic [6:0] MIN7      = 7'(DIV_MIN);
    localparam logic [6:0] MAX7      = 7'(DIV_MAX);
    localparam logic [6:0] RESET7    = 7'(DIV_RESET);
    localparam logic [9:0] DEB_LAST  = 10'(DEB_MS - 1);
    localparam logic [9:0] DLY_LAST  = 10'(REPEAT_DELAY_MS - 1);
    localparam logic [9:0] RATE_LAST = 10'(REPEAT_RATE_MS - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

    logic [1:0] tick_sync, up_sync, dn_sync;
    logic       tick_d;
    logic       ms_tick;
    logic [1:0] raw_s;          // [0] = up, [1] = dn
    logic [1:0] deb, deb_d;
    logic [9:0] deb_cnt [2];

    state_t     state, state_nxt;
    logic       dir, dir_nxt;   // 1 = stepping up
    logic [9:0] timer, timer_nxt;
    logic       step;
    logic [6:0] div_nxt;
    logic       u, d, u_rise, d_rise, held, other;

    assign ms_tick = tick_sync[1] & ~tick_d;
    assign raw_s   = {dn_sync[1], up_sync[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_sync <= '0;
            up_sync   <= '0;
            dn_sync   <= '0;
            tick_d    <= 1'b0;
        end else begin
            tick_sync <= {tick_sync[0], tick_src};
            up_sync   <= {up_sync[0], btn_up};
            dn_sync   <= {dn_sync[0], btn_dn};
            tick_d    <= tick_sync[1];
        end
    end

    // Counter measures how long the synced level has disagreed with the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb        <= '0;
            deb_d      <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (raw_s[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (ms_tick) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= raw_s[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 10'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir   <= 1'b1;
            timer <= '0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        timer_nxt = timer;
        step      = 1'b0;
        u         = deb[0];
        d         = deb[1];
        u_rise    = deb[0] & ~deb_d[0];
        d_rise    = deb[1] & ~deb_d[1];
        held      = dir ? u : d;
        other     = dir ? d : u;
        case (state)
            IDLE: begin
                if (u && d) begin
                    state_nxt = LOCK;
                end else if (u_rise) begin
                    step      = 1'b1;
                    dir_nxt   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = HOLD;
                end else if (d_rise) begin
                    step      = 1'b1;
                    dir_nxt   = 1'b0;
                    timer_nxt = '0;
                    state_nxt = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (other) begin
                    state_nxt = LOCK;
                end else if (!held) begin
                    state_nxt = IDLE;
                end else if (ms_tick) begin
                    if (timer == ((state == HOLD) ? DLY_LAST : RATE_LAST)) begin
                        step      = 1'b1;
                        timer_nxt = '0;
                        state_nxt = REPEAT;
                    end else begin
                        timer_nxt = timer + 10'd1;
                    end
                end
            end
            LOCK: begin
                if (!u && !d) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating step; a step at a limit keeps div and suppresses changed.
    always_comb begin
        div_nxt = div;
        if (step) begin
            if (dir_nxt) div_nxt = (div >= MAX7) ? div : div + 7'd1;
            else         div_nxt = (div <= MIN7) ? div : div - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= RESET7;
            changed <= 1'b0;
            at_min  <= (RESET7 == MIN7);
            at_max  <= (RESET7 == MAX7);
        end else begin
            div     <= div_nxt;
            changed <= (div_nxt != div);
            at_min  <= (div_nxt == MIN7);
            at_max  <= (div_nxt == MAX7);
        end
    end

endmodule

// File: tb/tb_div_selector.sv
// Bench for div_selector: 1 ms is compressed to two clocks of tick_src; expected values come
// from hand tables and from a press-duration model of debounce plus auto-repeat.
module tb_div_selector;

    localparam int DEB  = 20;
    localparam int DLY  = 500;
    localparam int RATE = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_src = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [6:0] div;
    logic       changed, at_min, at_max;

    int n_vec = 0;
    int n_bad = 0;
    int chg_cnt = 0;
    int chg_base = 0;
    int model = 49;
    bit prev_chg = 1'b0;

    typedef struct {
        bit up;
        int hold;
        int gap;
        int exp_div;
        int exp_pulses;
    } vec_t;

    vec_t tbl [8];

    bit r_up;
    int r_hold, r_gap, r_prev;

    div_selector dut (
        .clk      (clk),
        .rst      (rst),
        .tick_src (tick_src),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .div      (div),
        .changed  (changed),
        .at_min   (at_min),
        .at_max   (at_max)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary required one");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        model = 49;
    endtask

    // ---------------- drivers ----------------
    task automatic ms_step();
        @(negedge clk) tick_src = 1'b1;
        @(negedge clk) tick_src = 1'b0;
    endtask

    task automatic ms_run(input int n);
        repeat (n) ms_step();
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input bit up, input int hold, input int gap);
        if (up) btn_up = 1'b1;
        else    btn_dn = 1'b1;
        ms_run(hold);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        ms_run(gap);
        settle();
    endtask

    // ---------------- reference model ----------------
    // A press held for 'hold' ms is accepted iff hold >= DEB; it steps once at acceptance, again
    // after DLY ms, then every RATE ms while still held. Result is clamped to [1,99].
    function automatic int ref_after(input int v, input bit up, input int hold);
        int n;
        if (hold < DEB) return v;
        n = 1;
        if (hold >= DLY) n += 1 + (hold - DLY) / RATE;
        v = up ? v + n : v - n;
        if (v > 99) v = 99;
        if (v < 1)  v = 1;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input int exp_div, input int exp_pulses);
        check({name, ".div"}, int'(div), exp_div);
        check({name, ".at_min"}, int'(at_min), int'(exp_div == 1));
        check({name, ".at_max"}, int'(at_max), int'(exp_div == 99));
        check({name, ".pulses"}, chg_cnt - chg_base, exp_pulses);
    endtask

    always @(negedge clk) begin
        if (changed) begin
            chg_cnt++;
            n_vec++;
            if (prev_chg) begin
                n_bad++;
                $display("FAIL changed_back_to_back: got 2 consecutive pulses, expected 1");
            end
        end
        prev_chg = changed;
    end

    // ---------------- test sequence ----------------
    initial begin
        tbl[0] = '{1'b0,   19, 30, 50, 0};
        tbl[1] = '{1'b1,    8, 30, 50, 0};
        tbl[2] = '{1'b0,   20, 30, 49, 1};
        tbl[3] = '{1'b0,  499, 30, 48, 1};
        tbl[4] = '{1'b1,  501, 30, 50, 2};
        tbl[5] = '{1'b1,  599, 30, 52, 2};
        tbl[6] = '{1'b1,  601, 30, 55, 3};
        tbl[7] = '{1'b0, 1150, 30, 47, 8};

        // reset state and idle stability
        do_reset();
        check("rst.changed", int'(changed), 0);
        chg_base = chg_cnt;
        check_state("rst", 49, 0);
        ms_run(50);
        settle();
        check_state("idle50", 49, 0);

        // short glitches never accepted
        chg_base = chg_cnt;
        repeat (5) press(1'b1, 8, 8);
        ms_run(30);
        settle();
        check_state("glitch", 49, 0);

        // exact debounce latency
        chg_base = chg_cnt;
        btn_up = 1'b1;
        ms_run(DEB - 1);
        settle();
        check_state("deb19", 49, 0);
        ms_run(1);
        settle();
        check_state("deb20", 50, 1);
        btn_up = 1'b0;
        ms_run(30);
        settle();
        model = 50;

        // table-driven presses
        for (int i = 0; i < 8; i++) begin
            chg_base = chg_cnt;
            press(tbl[i].up, tbl[i].hold, tbl[i].gap);
            check_state($sformatf("tbl%0d", i), tbl[i].exp_div, tbl[i].exp_pulses);
        end

        // hold with release 1150 ms after the first step
        do_reset();
        chg_base = chg_cnt;
        press(1'b1, 1170, 30);
        check_state("repeat1150", 57, 8);

        // upper limit saturation
        chg_base = chg_cnt;
        press(1'b1, 4400, 30);
        check_state("to98", 98, 41);
        chg_base = chg_cnt;
        press(1'b1, 2000, 30);
        check_state("sat_max", 99, 1);

        // lower limit saturation
        do_reset();
        chg_base = chg_cnt;
        press(1'b0, 5000, 30);
        check_state("to2", 2, 47);
        chg_base = chg_cnt;
        press(1'b0, 2000, 30);
        check_state("sat_min", 1, 1);
        chg_base = chg_cnt;
        press(1'b1, 20, 30);
        check_state("leave_min", 2, 1);

        // simultaneous press locks out stepping
        do_reset();
        chg_base = chg_cnt;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        ms_run(700);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        ms_run(40);
        settle();
        check_state("lock_both", 49, 0);

        // second button during hold cancels repeat
        chg_base = chg_cnt;
        btn_up = 1'b1;
        ms_run(100);
        btn_dn = 1'b1;
        ms_run(1000);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        ms_run(40);
        settle();
        check_state("lock_hold", 50, 1);

        // lock persists until both released
        chg_base = chg_cnt;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        ms_run(50);
        btn_dn = 1'b0;
        ms_run(800);
        btn_up = 1'b0;
        ms_run(40);
        settle();
        check_state("lock_one", 50, 0);

        // reset during repeat, then held button counts as a new press
        chg_base = chg_cnt;
        btn_up = 1'b1;
        ms_run(700);
        settle();
        check_state("pre_rst", 53, 3);
        do_reset();
        chg_base = chg_cnt;
        check("rst_rep.changed", int'(changed), 0);
        check_state("rst_rep", 49, 0);
        ms_run(DEB - 1);
        settle();
        check_state("rst_rep19", 49, 0);
        ms_run(1);
        settle();
        check_state("rst_rep20", 50, 1);
        btn_up = 1'b0;
        ms_run(40);
        settle();
        model = 50;

        // randomized presses against the model
        for (int i = 0; i < 10; i++) begin
            r_up   = 1'($urandom_range(0, 1));
            r_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB - 1))
                                                 : int'($urandom_range(DEB, 800));
            r_gap  = int'($urandom_range(25, 60));
            r_prev = model;
            chg_base = chg_cnt;
            press(r_up, r_hold, r_gap);
            model = ref_after(model, r_up, r_hold);
            check_state($sformatf("rnd%0d", i), model,
                        (model > r_prev) ? model - r_prev : r_prev - model);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
